// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus constants used by target and initiator.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WDATA,
    WACK,
    RDATA,
    RACK,
    IGNORE
  } state_t;

  localparam logic       I2C_RW_READ   = 1'b1;
  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for the SCL/SDA pair with SCL edge pulses and START/STOP detection.
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // Bit 2 holds the previous synchronised value for edge detection.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_o     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer: writes go out on reg_we_o, reads are fetched via reg_re_o.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h39,
  parameter int unsigned DATA_HOLD   = 5,
  parameter int unsigned REG_AW      = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              scl_i,
  inout  wire               sda_io,
  output logic [REG_AW-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  output logic              reg_we_o,
  input  logic [7:0]        reg_rdata_i,
  output logic              reg_re_o,
  output logic              busy_o
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_sync_edge u_sync (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .scl_i      (scl_i),
    .sda_i      (sda_io),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        rx_q, tx_q, wdata_q;
  logic [REG_AW-1:0] ptr_q;
  logic              we_q, we_d, re_q, re_d;
  logic              oe_q, sda_nxt_q;
  logic [3:0]        hold_q;
  logic              shift_rx, shift_tx, ptr_ld;
  logic              sched, sched_low, release_now;
  logic [7:0]        rx_byte;

  assign rx_byte = {rx_q[6:0], sda_s};

  // Bits are taken on SCL rise; SDA drive changes are scheduled on SCL fall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_rx    = 1'b0;
    shift_tx    = 1'b0;
    ptr_ld      = 1'b0;
    we_d        = 1'b0;
    re_d        = 1'b0;
    sched       = 1'b0;
    sched_low   = 1'b0;
    release_now = 1'b0;
    if (stop_det) begin
      state_d     = IDLE;
      cnt_d       = '0;
      release_now = 1'b1;
    end else if (start_det) begin
      state_d     = ADDR;
      cnt_d       = '0;
      release_now = 1'b1;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (cnt_q != BITS_PER_BYTE) begin
            shift_rx = 1'b1;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == BITS_PER_BYTE - 4'd1) begin
              ptr_ld = (state_q == PTR);
              we_d   = (state_q == WDATA);
            end
          end
        end
        RDATA:   if (cnt_q != BITS_PER_BYTE) cnt_d = cnt_q + 4'd1;
        RACK:    if (sda_s) state_d = IGNORE;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ADDR: begin
          if (cnt_q == BITS_PER_BYTE) begin
            cnt_d = '0;
            sched = 1'b1;
            if (rx_q[7:1] == TARGET_ADDR) begin
              state_d   = ADDR_ACK;
              sched_low = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          sched = 1'b1;
          if (rx_q[0] == I2C_RW_READ) begin
            state_d = RDATA;
            re_d    = 1'b1;
          end else begin
            state_d = PTR;
          end
        end
        PTR, WDATA: begin
          if (cnt_q == BITS_PER_BYTE) begin
            cnt_d     = '0;
            state_d   = WACK;
            sched     = 1'b1;
            sched_low = 1'b1;
          end
        end
        WACK: begin
          state_d = WDATA;
          sched   = 1'b1;
        end
        RDATA: begin
          sched = 1'b1;
          if (cnt_q == BITS_PER_BYTE) begin
            state_d = RACK;
            cnt_d   = '0;
          end else begin
            sched_low = ~tx_q[7];
            shift_tx  = 1'b1;
          end
        end
        RACK: begin
          state_d = RDATA;
          re_d    = 1'b1;
          sched   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Register port: reg_we_o/reg_re_o are single-cycle strobes with no backpressure;
  // reg_rdata_i is captured in the cycle reg_re_o is high, then the pointer advances.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      wdata_q   <= '0;
      ptr_q     <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      oe_q      <= 1'b0;
      sda_nxt_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      re_q    <= re_d;
      if (shift_rx) rx_q <= rx_byte;
      if (we_d) wdata_q <= rx_byte;
      if (ptr_ld) ptr_q <= REG_AW'(rx_byte);
      else if (we_q || re_q) ptr_q <= ptr_q + REG_AW'(1);
      if (re_q) tx_q <= {reg_rdata_i[6:0], 1'b0};
      else if (shift_tx) tx_q <= {tx_q[6:0], 1'b0};
      if (release_now) begin
        oe_q   <= 1'b0;
        hold_q <= '0;
      end else if (sched) begin
        hold_q    <= 4'(DATA_HOLD);
        sda_nxt_q <= sched_low;
      end else if (hold_q != 4'd0) begin
        hold_q <= hold_q - 4'd1;
        if (hold_q == 4'd1) oe_q <= sda_nxt_q;
      end
      if (re_q) sda_nxt_q <= ~reg_rdata_i[7];
    end
  end

  assign sda_io      = oe_q ? 1'b0 : 1'bz;
  assign reg_addr_o  = ptr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign busy_o      = state_q inside {ADDR_ACK, PTR, WACK, WDATA, RDATA, RACK};

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C initiator, register-file model and write scoreboard.
module tb_i2c_target;

  localparam int         Q     = 10;
  localparam logic [6:0] TADDR = 7'h39;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic tb_low = 1'b0;
  wire  sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic reg_we, reg_re, busy;

  assign sda = tb_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign reg_rdata = reg_addr ^ 8'hA5;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .scl_i       (scl),
    .sda_io      (sda),
    .reg_addr_o  (reg_addr),
    .reg_wdata_o (reg_wdata),
    .reg_we_o    (reg_we),
    .reg_rdata_i (reg_rdata),
    .reg_re_o    (reg_re),
    .busy_o      (busy)
  );

  int n_err = 0;
  int n_checks = 0;
  logic [7:0]  ptr_m = 8'h00;
  logic [7:0]  wbytes[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int got_rd = 0;
  int re_seen = 0;
  int sda_glitch = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_low = 1'b0, prev_rst = 1'b0;

  // Bus monitor: strobes into the observed queue, SDA stability while SCL is high.
  always begin
    @(negedge clk);
    #2;
    if (reg_we) got_q.push_back({reg_addr, reg_wdata});
    if (reg_re) re_seen++;
    if (scl && prev_scl && rst_n && prev_rst && (tb_low == prev_low) && (sda !== prev_sda))
      sda_glitch++;
    prev_scl = scl;
    prev_sda = sda;
    prev_low = tb_low;
    prev_rst = rst_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    tb_low = 1'b0; wait_clk(Q);
    scl = 1'b1;    wait_clk(Q);
    tb_low = 1'b1; wait_clk(Q);
    scl = 1'b0;    wait_clk(Q);
  endtask

  task automatic stop_cond();
    tb_low = 1'b1; wait_clk(Q);
    scl = 1'b1;    wait_clk(Q);
    tb_low = 1'b0; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    tb_low = ~b; wait_clk(Q);
    scl = 1'b1;  wait_clk(2 * Q);
    scl = 1'b0;  wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    tb_low = 1'b0; wait_clk(Q);
    scl = 1'b1;    wait_clk(Q);
    b = sda;       wait_clk(Q);
    scl = 1'b0;    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  task automatic score();
    check("we_count", 32'(got_q.size() - got_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      check("we_addr_data", got_q[got_rd], exp_q.pop_front());
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  // First byte after the address is the pointer; each further byte writes and advances it.
  task automatic do_write(input logic [6:0] a);
    logic ack;
    logic match;
    match = (a == TADDR);
    start_cond();
    write_byte({a, 1'b0}, ack);
    check("w_addr_ack", ack, !match);
    check("w_busy", busy, match);
    foreach (wbytes[i]) begin
      write_byte(wbytes[i], ack);
      check("w_data_ack", ack, !match);
      if (match) begin
        if (i == 0) ptr_m = wbytes[i];
        else begin
          exp_q.push_back({ptr_m, wbytes[i]});
          ptr_m++;
        end
      end
    end
    stop_cond();
    wait_clk(4);
    check("w_busy_stop", busy, 1'b0);
    check("w_ptr", reg_addr, ptr_m);
    score();
  endtask

  task automatic set_ptr(input logic [7:0] p);
    logic ack;
    start_cond();
    write_byte({TADDR, 1'b0}, ack);
    check("p_addr_ack", ack, 1'b0);
    write_byte(p, ack);
    check("p_ptr_ack", ack, 1'b0);
    ptr_m = p;
  endtask

  task automatic do_read(input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    int re_base;
    set_ptr(p);
    re_base = re_seen;
    start_cond();
    write_byte({TADDR, 1'b1}, ack);
    check("r_addr_ack", ack, 1'b0);
    check("r_busy", busy, 1'b1);
    for (int k = 0; k < n; k++) begin
      read_byte(d);
      check("r_data", d, ptr_m ^ 8'hA5);
      ptr_m++;
      write_bit(k == n - 1);
    end
    wait_clk(Q);
    check("r_sda_released", sda, 1'b1);
    check("r_busy_nack", busy, 1'b0);
    stop_cond();
    wait_clk(4);
    check("r_re_count", 32'(re_seen - re_base), 32'(n));
    check("r_ptr", reg_addr, ptr_m);
    score();
  endtask

  initial begin
    logic [7:0] p;
    logic [6:0] fa;
    int kind;
    int nb;
    logic ack;

    wait_clk(3);
    check("rst_addr", reg_addr, 8'h00);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_we", reg_we, 1'b0);
    check("rst_re", reg_re, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", sda, 1'b1);
    rst_n = 1'b1;
    wait_clk(3);

    wbytes = '{8'h41, 8'h10};
    do_write(TADDR);
    wbytes = '{8'h00};
    do_write(7'h3A);
    wbytes = '{8'hFF, 8'hAA, 8'hBB};
    do_write(TADDR);
    do_read(8'h05, 2);

    // Byte cut short by STOP after four bits.
    set_ptr(8'h5C);
    for (int i = 0; i < 4; i++) write_bit(1'($urandom_range(0, 1)));
    stop_cond();
    wait_clk(4);
    check("part_busy", busy, 1'b0);
    check("part_ptr", reg_addr, ptr_m);
    score();

    for (int t = 0; t < 8; t++) begin
      kind = $urandom_range(0, 3);
      nb   = $urandom_range(1, 3);
      p    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      wbytes = '{p};
      for (int i = 0; i < nb; i++) wbytes.push_back(8'($urandom));
      if (kind == 0) begin
        fa = 7'($urandom_range(0, 127));
        if (fa == TADDR) fa = 7'h3A;
        do_write(fa);
      end else if (kind == 3) begin
        do_read(p, nb);
      end else begin
        do_write(TADDR);
      end
    end

    // Async reset while the target holds SDA low on the first read bit (0x80^0xA5 = 0x25).
    set_ptr(8'h80);
    start_cond();
    write_byte({TADDR, 1'b1}, ack);
    check("rr_addr_ack", ack, 1'b0);
    tb_low = 1'b0; wait_clk(Q);
    scl = 1'b1;    wait_clk(Q);
    check("rr_sda_low", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rr_sda_released", sda, 1'b1);
    check("rr_addr", reg_addr, 8'h00);
    check("rr_wdata", reg_wdata, 8'h00);
    check("rr_we", reg_we, 1'b0);
    check("rr_re", reg_re, 1'b0);
    check("rr_busy", busy, 1'b0);
    wait_clk(3);
    rst_n = 1'b1;
    ptr_m = 8'h00;
    got_rd = got_q.size();
    wait_clk(3);
    scl = 1'b0;
    wait_clk(Q);
    wbytes = '{8'h33, 8'h44};
    do_write(TADDR);

    check("sda_stable_scl_high", sda_glitch, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
